vga_scan_ctrl: RTL

Scan-out controller for the VGA subsystem: generates 640x480@60 timing, sequences reads of 8-bit colour indices from a single-port framebuffer RAM, converts them through an internal `color_map` instance and drives the pixel pins. It also shares the framebuffer port with CPU writes through a req/ack handshake, giving scan-out fetches strict priority.

---
 rtl/vga_scan_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_scan_ctrl.sv
`timescale 1ns/1ps
// vga_scan_ctrl: 640x480@60 scan-out from a 160x120 indexed framebuffer.
// CPU writes use the RAM port cycles that scan-out fetches leave free.

module color_map (
  input  logic [7:0]  idx_i,
  output logic [23:0] rgb_o
);
  always_comb begin
    rgb_o = 24'h000000;
    case (idx_i)
      8'h01:   rgb_o = 24'hFF0000;
      8'h02:   rgb_o = 24'h00FF00;
      8'h03:   rgb_o = 24'h0000FF;
      8'h04:   rgb_o = 24'hFFFFFF;
      default: rgb_o = 24'h000000;
    endcase
  end
endmodule

module vga_scan_ctrl #(
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int FB_AW = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [FB_AW-1:0] cpu_addr,
  input  logic [7:0]       cpu_data,
  output logic             cpu_ack,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_we,
  output logic [7:0]       fb_wdata,
  input  logic [7:0]       fb_rdata,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             frame_irq
);

  localparam logic [FB_AW:0] FB_SIZE = (FB_AW+1)'(FB_W * FB_H);

  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             active, fetch, hs_n, vs_n;
  logic [7:0]       row, col;
  logic [FB_AW-1:0] rd_addr;
  logic             wr_ok, wr_valid;

  logic             ack_q, we_q, irq_q;
  logic [FB_AW-1:0] addr_q;
  logic [7:0]       wdata_q;
  logic             rd_q, rd2_q;
  logic [7:0]       idx_q;
  logic [3:0]       hs_p_q, vs_p_q, act_p_q;
  logic [23:0]      rgb_q, map_rgb;

  always_comb begin
    h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'd799)
      v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
  end

  assign active = (h_q < 10'd640) && (v_q < 10'd480);
  assign fetch  = active && (h_q[1:0] == 2'b00);
  assign hs_n   = !((h_q >= 10'd656) && (h_q <= 10'd751));
  assign vs_n   = !((v_q >= 10'd490) && (v_q <= 10'd491));

  // Entry address = row*160 + col, with x160 split as x128 + x32.
  assign row     = v_q[9:2];
  assign col     = h_q[9:2];
  assign rd_addr = FB_AW'({row, 7'b0}) + FB_AW'({row, 5'b0}) + FB_AW'(col);

  // The cycle after an ack ignores cpu_req, so a held request is not served twice.
  assign wr_ok    = cpu_req && !ack_q && !fetch;
  assign wr_valid = {1'b0, cpu_addr} < FB_SIZE;

  color_map u_cmap (
    .idx_i (idx_q),
    .rgb_o (map_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      irq_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      rd2_q   <= 1'b0;
      idx_q   <= '0;
      hs_p_q  <= 4'hF;
      vs_p_q  <= 4'hF;
      act_p_q <= 4'h0;
      rgb_q   <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      irq_q <= (h_d == 10'd0) && (v_d == 10'd480);

      ack_q <= 1'b0;
      we_q  <= 1'b0;
      if (fetch) begin
        addr_q <= rd_addr;
      end else if (wr_ok) begin
        ack_q <= 1'b1;
        if (wr_valid) begin
          we_q    <= 1'b1;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_data;
        end
      end

      // rd_q marks the read cycle, rd2_q the cycle the RAM returns data.
      rd_q  <= fetch;
      rd2_q <= rd_q;
      if (rd2_q)
        idx_q <= fb_rdata;

      hs_p_q  <= {hs_p_q[2:0], hs_n};
      vs_p_q  <= {vs_p_q[2:0], vs_n};
      act_p_q <= {act_p_q[2:0], active};
      rgb_q   <= act_p_q[2] ? map_rgb : 24'h000000;
    end
  end

  assign cpu_ack     = ack_q;
  assign fb_we       = we_q;
  assign fb_addr     = addr_q;
  assign fb_wdata    = wdata_q;
  assign frame_irq   = irq_q;
  assign vga_hs      = hs_p_q[3];
  assign vga_vs      = vs_p_q[3];
  assign vga_blank_n = act_p_q[3];
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule
